// File: rtl/mem_pkg.sv
// Shared types and helpers for the OTTER load/store port: access size, FSM
// state, byte-enable generation and load-data extension.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_BYTE: byte_en = 4'b0001 << off;
      MEM_HALF: byte_en = 4'b0011 << off;
      default:  byte_en = 4'b1111;
    endcase
  endfunction

  // Word loads are always aligned, so the shift is a no-op for them.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic uns);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      MEM_BYTE: load_ext = {{24{sh[7] & ~uns}}, sh[7:0]};
      MEM_HALF: load_ext = {{16{sh[15] & ~uns}}, sh[15:0]};
      default:  load_ext = sh;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables and replication, load
// alignment and extension.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [1:0]  wr_off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_off,
  input  logic        rd_uns,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  assign be = byte_en(wr_size, wr_off);

  // Replicate the right-justified datum into every lane it may land in.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign wdata_lane[8*i +: 8] = (wr_size == MEM_BYTE) ? wdata[7:0] :
                                  (wr_size == MEM_HALF) ? wdata[8*(i%2) +: 8] :
                                                          wdata[8*i +: 8];
  end

  assign rdata_ext = load_ext(rdata, rd_size, rd_off, rd_uns);

endmodule

// File: rtl/mem_initiator.sv
// CPU-side load/store port for the OTTER block RAM: one request at a time,
// registered strobes, one-cycle registered RAM read captured and extended.
module mem_initiator
  import mem_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 13,
  parameter int RAM_BUS_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [31:0]               req_addr,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic                      mem_rd_n,
  output logic [3:0]                mem_we,
  output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
  output logic [RAM_BUS_WIDTH-1:0]  mem_wdata,
  input  logic [RAM_BUS_WIDTH-1:0]  mem_rdata
);

  state_t     state;
  logic       r_we;
  logic       r_uns;
  logic [1:0] r_size;
  logic [1:0] r_off;

  logic        req_err;
  logic [3:0]  be;
  logic [31:0] wdata_lane;
  logic [31:0] rdata_ext;

  assign req_err = (req_size == 2'd3)
                || ((req_size == MEM_HALF) && req_addr[0])
                || ((req_size == MEM_WORD) && (req_addr[1:0] != 2'b00))
                || (|req_addr[31:RAM_ADDR_WIDTH+2]);

  mem_align u_align (
    .wr_size   (req_size),
    .wr_off    (req_addr[1:0]),
    .wdata     (req_wdata),
    .be        (be),
    .wdata_lane(wdata_lane),
    .rd_size   (r_size),
    .rd_off    (r_off),
    .rd_uns    (r_uns),
    .rdata     (mem_rdata),
    .rdata_ext (rdata_ext)
  );

  // Outputs are loaded on the edge that enters a state, so each strobe is
  // visible for exactly the cycle the FSM spends in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_rd_n   <= 1'b1;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= '0;
      r_off      <= '0;
    end else begin
      resp_valid <= 1'b0;
      mem_rd_n   <= 1'b1;
      mem_we     <= '0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            r_we       <= req_we;
            r_uns      <= req_unsigned;
            r_size     <= req_size;
            r_off      <= req_addr[1:0];
            resp_rdata <= '0;
            resp_err   <= req_err;
            if (req_err) begin
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else begin
              mem_addr <= req_addr[RAM_ADDR_WIDTH+1:2];
              if (req_we) begin
                mem_we    <= be;
                mem_wdata <= wdata_lane;
              end else begin
                mem_rd_n <= 1'b0;
              end
              state <= ST_ISSUE;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (r_we) begin
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          resp_rdata <= rdata_ext;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: behavioural RAM plus a byte-array reference model
// of the memory, directed cases and randomized request streams.
module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd_n;
  logic [3:0]  mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int we_cnt = 0;
  int overlap_cnt = 0;

  logic [31:0] ram    [0:8191];
  logic [7:0]  refmem [0:32767];

  always #5 clk = ~clk;

  mem_initiator #(.RAM_ADDR_WIDTH(13), .RAM_BUS_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rd_n(mem_rd_n), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = 32'(i) * 32'h9E37_79B9;
    return w ^ 32'h5A5A_1234;
  endfunction

  // Behavioural 8K x 32 RAM with registered read.
  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (!mem_rd_n) mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    if (!mem_rd_n) rd_cnt++;
    if (mem_we != 4'b0) we_cnt++;
    if (!mem_rd_n && mem_we != 4'b0) overlap_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input logic [1:0] size);
    if (size == 2'd3) return 1'b1;
    if ((a % size_bytes(size)) != 0) return 1'b1;
    return a >= 32'h8000;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] size, input logic uns);
    int n;
    logic [31:0] v;
    n = size_bytes(size);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(refmem[int'(a) + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] size);
    logic [3:0] be;
    be = '0;
    for (int i = 0; i < size_bytes(size); i++) be[int'(a[1:0]) + i] = 1'b1;
    return be;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] d);
    for (int i = 0; i < size_bytes(size); i++) refmem[int'(a) + i] = d[8*i +: 8];
  endtask

  // Drives one request and reports what the DUT did; comparisons are made by callers.
  task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] size,
                       input logic uns, input logic [31:0] d,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output logic [3:0] we1, output logic [12:0] addr1,
                       output logic [31:0] wdata1, output logic rdn1,
                       output int rd_d, output int we_d, output logic pulse_ok);
    int n, rd0, we0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = a; req_size = size;
    req_unsigned = uns; req_wdata = d;
    @(posedge clk);
    rd0 = rd_cnt; we0 = we_cnt;
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wdata = $urandom;
    we1 = mem_we; addr1 = mem_addr; wdata1 = mem_wdata; rdn1 = mem_rd_n;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
    rdata = resp_rdata; err = resp_err;
    @(posedge clk); #1;
    pulse_ok = (resp_valid === 1'b0);
    rd_d = rd_cnt - rd0; we_d = we_cnt - we0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_resp: ready=%b valid=%b err=%b rdata=%h required 0/0/0/0",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if (mem_rd_n !== 1'b1 || mem_we !== 4'h0 || mem_addr !== 13'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mem: rd_n=%b we=%h addr=%h wdata=%h required 1/0/0/0",
               mem_rd_n, mem_we, mem_addr, mem_wdata);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_store;
    int lat, rd_d, we_d; logic [31:0] rd, wd1; logic err, rdn1, pok; logic [3:0] we1; logic [12:0] a1;
    issue(1'b1, 32'h40, 2'd2, 1'b0, 32'hDEAD_BEEF, lat, rd, err, we1, a1, wd1, rdn1, rd_d, we_d, pok);
    model_store(32'h40, 2'd2, 32'hDEAD_BEEF);
    checks++;
    if (we1 !== 4'b1111 || a1 !== 13'h10 || wd1 !== 32'hDEAD_BEEF || rdn1 !== 1'b1) begin
      failures++;
      $display("FAIL word_store_port: we=%b addr=%h wdata=%h rd_n=%b required 1111/010/deadbeef/1", we1, a1, wd1, rdn1);
    end
    checks++;
    if (lat != 2 || err !== 1'b0 || !pok || we_d != 1) begin
      failures++;
      $display("FAIL word_store_resp: lat=%0d err=%b pulse=%b we_cycles=%0d required 2/0/1/1", lat, err, pok, we_d);
    end
    issue(1'b1, 32'h41, 2'd0, 1'b0, 32'h0000_00A5, lat, rd, err, we1, a1, wd1, rdn1, rd_d, we_d, pok);
    model_store(32'h41, 2'd0, 32'h0000_00A5);
    checks++;
    if (we1 !== 4'b0010 || wd1 !== 32'hA5A5_A5A5 || lat != 2) begin
      failures++;
      $display("FAIL byte_store: we=%b wdata=%h lat=%0d required 0010/a5a5a5a5/2", we1, wd1, lat);
    end
    issue(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, lat, rd, err, we1, a1, wd1, rdn1, rd_d, we_d, pok);
    checks++;
    if (rd !== 32'hDEAD_A5EF || lat != 3 || rdn1 !== 1'b0 || we1 !== 4'h0 || rd_d != 1) begin
      failures++;
      $display("FAIL word_readback: rdata=%h lat=%0d rd_n=%b rd_cycles=%0d required deada5ef/3/0/1", rd, lat, rdn1, rd_d);
    end
  endtask

  task automatic test_load_ext;
    int lat, rd_d, we_d; logic [31:0] rd, wd1; logic err, rdn1, pok; logic [3:0] we1; logic [12:0] a1;
    logic [31:0] a_tab [4]; logic [1:0] s_tab [4]; logic u_tab [4]; logic [31:0] e_tab [4];
    a_tab = '{32'h42, 32'h42, 32'h43, 32'h40};
    s_tab = '{2'd1, 2'd1, 2'd0, 2'd2};
    u_tab = '{1'b0, 1'b1, 1'b0, 1'b0};
    e_tab = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FF80, 32'h8001_1234};
    issue(1'b1, 32'h40, 2'd2, 1'b0, 32'h8001_1234, lat, rd, err, we1, a1, wd1, rdn1, rd_d, we_d, pok);
    model_store(32'h40, 2'd2, 32'h8001_1234);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, a_tab[i], s_tab[i], u_tab[i], 32'h0, lat, rd, err, we1, a1, wd1, rdn1, rd_d, we_d, pok);
      checks++;
      if (rd !== e_tab[i] || lat != 3 || err !== 1'b0 || !pok) begin
        failures++;
        $display("FAIL load_ext[%0d]: rdata=%h lat=%0d err=%b pulse=%b required %h/3/0/1", i, rd, lat, err, pok, e_tab[i]);
      end
    end
  endtask

  task automatic test_errors;
    int lat, rd_d, we_d; logic [31:0] rd, wd1; logic err, rdn1, pok; logic [3:0] we1; logic [12:0] a1;
    logic [31:0] a_tab [4]; logic [1:0] s_tab [4];
    a_tab = '{32'h41, 32'h42, 32'h0, 32'h0001_0000};
    s_tab = '{2'd1, 2'd2, 2'd3, 2'd2};
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin
        issue(1'(w), a_tab[i], s_tab[i], 1'b0, 32'hFFFF_FFFF, lat, rd, err, we1, a1, wd1, rdn1, rd_d, we_d, pok);
        checks++;
        if (err !== 1'b1 || lat != 1 || rd !== 32'h0 || rd_d != 0 || we_d != 0 || !pok) begin
          failures++;
          $display("FAIL error[%0d,%0d]: err=%b lat=%0d rdata=%h rd_cycles=%0d we_cycles=%0d required 1/1/0/0/0",
                   w, i, err, lat, rd, rd_d, we_d);
        end
      end
    end
  endtask

  task automatic test_random;
    int lat, rd_d, we_d, elat; logic [31:0] rd, wd1, a, d; logic err, rdn1, pok, we, uns, eerr;
    logic [3:0] we1; logic [12:0] a1; logic [1:0] sz; logic [31:0] erd;
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom); uns = 1'($urandom); d = $urandom;
      sz = 2'($urandom_range(0, 3));
      a = 32'h100 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(15, 31));
      eerr = exp_err(a, sz);
      elat = eerr ? 1 : (we ? 2 : 3);
      erd  = (eerr || we) ? 32'h0 : exp_load(a, sz, uns);
      issue(we, a, sz, uns, d, lat, rd, err, we1, a1, wd1, rdn1, rd_d, we_d, pok);
      if (!eerr && we) model_store(a, sz, d);
      checks++;
      if (err !== eerr || lat != elat || rd !== erd || !pok) begin
        failures++;
        $display("FAIL rand[%0d] we=%b a=%h sz=%0d: err=%b lat=%0d rdata=%h required %b/%0d/%h",
                 k, we, a, sz, err, lat, rd, eerr, elat, erd);
      end
      if (!eerr && we) begin
        checks++;
        if (we1 !== exp_be(a, sz) || a1 !== a[14:2] || we_d != 1 || rd_d != 0) begin
          failures++;
          $display("FAIL rand_store[%0d]: we=%b addr=%h we_cycles=%0d rd_cycles=%0d required %b/%h/1/0",
                   k, we1, a1, we_d, rd_d, exp_be(a, sz), a[14:2]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int n, lat, rd_d, we_d; logic [31:0] rd, wd1; logic err, rdn1, pok, seen; logic [3:0] we1; logic [12:0] a1;
    n = 0; seen = 1'b0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_rd_n !== 1'b0) begin
      failures++;
      $display("FAIL mid_issue: mem_rd_n=%b required 0", mem_rd_n);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_rd_n !== 1'b1 || mem_we !== 4'h0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_async: rd_n=%b we=%h ready=%b required 1/0/0", mem_rd_n, mem_we, req_ready);
    end
    repeat (3) begin @(negedge clk); if (resp_valid === 1'b1) seen = 1'b1; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (resp_valid === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_resp: resp_seen=%b ready=%b required 0/1", seen, req_ready);
    end
    issue(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, lat, rd, err, we1, a1, wd1, rdn1, rd_d, we_d, pok);
    checks++;
    if (rd !== exp_load(32'h40, 2'd2, 1'b0) || lat != 3 || err !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_load: rdata=%h lat=%0d err=%b required %h/3/0",
               rd, lat, err, exp_load(32'h40, 2'd2, 1'b0));
    end
  endtask

  task automatic test_strobe_overlap;
    checks++;
    if (overlap_cnt != 0) begin
      failures++;
      $display("FAIL strobe_overlap: cycles=%0d required 0", overlap_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin
      logic [31:0] w;
      w = init_word(i);
      for (int b = 0; b < 4; b++) refmem[4*i + b] = w[8*b +: 8];
    end
    test_reset();
    test_store();
    test_load_ext();
    test_errors();
    test_random();
    test_reset_mid();
    test_strobe_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- CPU-side load/store port that drives the single-port byte-enabled block RAM in the OTTER multicycle core.
- Accepts one byte-addressed request per handshake. Converts it to a word address, byte enables and lane-shifted write data.
- Sequences the RAM's one-cycle registered read, then aligns and sign/zero-extends load data.
- Sits between the multicycle control FSM and the RAM; sole driver of the RAM port.

Parameters:
- RAM_ADDR_WIDTH, 13, word-address width of the attached RAM (8K x 32).
- RAM_BUS_WIDTH, 32, RAM data width; only 32 is supported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: misaligned, illegal size, or out-of-range.
- mem_rd_n  out  1  RAM read strobe, active-low; RAM reads when 0.
- mem_we  out  4  RAM byte write enables; bit i enables byte lane [8i+7:8i].
- mem_addr  out  RAM_ADDR_WIDTH  RAM word address = req_addr[RAM_ADDR_WIDTH+1:2].
- mem_wdata  out  32  lane-shifted store data.
- mem_rdata  in  32  RAM registered read data; valid the cycle after mem_rd_n=0 is sampled.

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0 while rst_n low, then 1 in IDLE; resp_valid=0, resp_rdata=0, resp_err=0, mem_rd_n=1, mem_we=0, mem_addr=0, mem_wdata=0; state=IDLE.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: req_ready=1. On req_valid, latch the request and check it.
  - Error if size=3, or half with addr[0]=1, or word with addr[1:0]!=0, or addr[31:RAM_ADDR_WIDTH+2]!=0.
  - Error -> RESP with err=1; no RAM strobe is ever asserted.
  - Otherwise -> ISSUE.
- ISSUE (1 cycle):
  - Load: mem_rd_n=0, mem_we=0.
  - Store: mem_rd_n=1; mem_we = byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; mem_wdata = wdata replicated per size (byte x4, half x2).
  - Load -> CAPTURE; store -> RESP.
- CAPTURE (1 cycle):
  - Strobes deasserted (mem_rd_n=1, mem_we=0).
  - Register mem_rdata shifted right by 8*addr[1:0], then extend from bit 7 (byte) or bit 15 (half) unless unsigned. Word passes through.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
- Latency, accept edge to resp_valid high:
  - load 3 cycles, store 2 cycles, error 1 cycle.
  - Back-to-back requests: one idle cycle minimum between accepts.
- mem_rd_n and mem_we are never active in the same cycle.
- mem_we is nonzero only in ISSUE.
- Request inputs are don't-care outside the IDLE accept cycle.
- Reset mid-operation:
  - All strobes drop asynchronously.
  - An in-flight store may or may not have been committed by the RAM.
  - No resp_valid is issued for the aborted request.

Decomposition:
- Shared package mem_pkg:
  - typedef enum mem_size_t {MEM_BYTE, MEM_HALF, MEM_WORD}
  - state enum
  - function for byte-enable generation
  - function for load extension
- One natural sub-module: mem_align, purely combinational, holding lane shift, replication and extension. Instantiated once.

Test Plan:
- Word store addr 0x40, wdata 0xDEADBEEF -> mem_we=4'b1111, mem_addr=0x10, resp_valid 2 cycles after accept, err=0.
- Byte store addr 0x41, wdata 0x000000A5 -> mem_we=4'b0010, mem_wdata=0xA5A5A5A5. Word read of 0x40 then returns 0xDEADA5EF.
- Signed half load addr 0x42 over word 0x8001_1234 -> resp_rdata=0xFFFF8001. Same with unsigned -> 0x00008001. resp_valid 3 cycles after accept.
- Signed byte load addr 0x43 over 0x80xxxxxx -> 0xFFFFFF80. Word load -> full word unchanged.
- Half load addr 0x41, word load addr 0x42, size=3, addr 0x0001_0000 -> resp_err=1 after 1 cycle, mem_rd_n stays 1 and mem_we stays 0 throughout.
- rst_n low during ISSUE of a load -> mem_rd_n=1 immediately, no resp_valid. After release, req_ready=1 and the next load completes normally.
